// File: rtl/argmax_row_sequencer.sv
// Per-row argmax sequencer: streams FEATURE_ROWS product rows and stores each row's max column index.
// Define ARGMAX_SIGNED_EN to compare rd_data elements as two's-complement signed values.
module argmax_row_sequencer #(
    parameter int MAX_ADDRESS_WIDTH = 2,
    parameter int WEIGHT_COLS       = 3,
    parameter int FEATURE_ROWS      = 6,
    parameter int DOT_PROD_WIDTH    = 16,
    localparam int ROW_ADDR_WIDTH   = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              rd_en,
    output logic [ROW_ADDR_WIDTH-1:0]                         rd_addr,
    input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]        rd_data,
    output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]    max_addi_ans
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(FEATURE_ROWS - 1);

    state_t                         state;
    state_t                         state_nxt;
    logic [ROW_ADDR_WIDTH-1:0]      row_cnt;
    logic                           cap_valid;
    logic [ROW_ADDR_WIDTH-1:0]      cap_tag;
    logic [MAX_ADDRESS_WIDTH-1:0]   row_argmax;
    logic                           run_accept;

    function automatic logic col_gt(input logic [DOT_PROD_WIDTH-1:0] a,
                                    input logic [DOT_PROD_WIDTH-1:0] b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (row_cnt == LAST_ROW) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run_accept = (state == IDLE) && start;
    assign rd_addr    = row_cnt;

    // Counter parks on the last row so rd_addr never leaves the valid range.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
        end else if (run_accept) begin
            row_cnt <= '0;
        end else if ((state == RUN) && (row_cnt != LAST_ROW)) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // Linear scan: a later column wins only when strictly greater, so ties keep the lowest index.
    always_comb begin
        logic [DOT_PROD_WIDTH-1:0] best_val;
        best_val   = rd_data[0];
        row_argmax = '0;
        for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
            if (col_gt(rd_data[c], best_val)) begin
                best_val   = rd_data[c];
                row_argmax = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

    // Valid/tag trail the read strobe by one cycle to line up with the memory's read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid    <= 1'b0;
            cap_tag      <= '0;
            max_addi_ans <= '0;
        end else begin
            cap_valid <= rd_en;
            cap_tag   <= row_cnt;
            if (run_accept) begin
                max_addi_ans <= '0;
            end else if (cap_valid) begin
                max_addi_ans[cap_tag] <= row_argmax;
            end
        end
    end

endmodule

// File: tb/tb_argmax_row_sequencer.sv
// Self-checking bench for argmax_row_sequencer: per-run expected argmax values are queued at
// start and popped against max_addi_ans on the done pulse, with cycle-exact handshake checks.
module tb_argmax_row_sequencer;

    localparam int MAW = 2;
    localparam int WC  = 3;
    localparam int FR  = 6;
    localparam int DW  = 16;
    localparam int RAW = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       rd_en;
    logic [RAW-1:0]             rd_addr;
    logic [WC-1:0][DW-1:0]      rd_data;
    logic [FR-1:0][MAW-1:0]     max_addi_ans;

    int n_vec = 0;
    int n_err = 0;

    logic [MAW-1:0]             exp_q[$];
    logic [WC-1:0][DW-1:0]      mem[FR];
    logic                       pend_en;
    logic [RAW-1:0]             pend_addr;

    argmax_row_sequencer #(
        .MAX_ADDRESS_WIDTH(MAW),
        .WEIGHT_COLS(WC),
        .FEATURE_ROWS(FR),
        .DOT_PROD_WIDTH(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .max_addi_ans(max_addi_ans)
    );

    always #5 clk = ~clk;

    // Product memory model: one-cycle read latency, garbage when not read.
    always @(negedge clk) begin
        pend_en   = rd_en;
        pend_addr = rd_addr;
    end

    always @(posedge clk) begin
        #1;
        if (pend_en === 1'b1) rd_data = mem[pend_addr];
        else rd_data = (WC*DW)'({$urandom(), $urandom()});
    end

    function automatic logic [MAW-1:0] ref_argmax(input logic [WC-1:0][DW-1:0] row);
        longint v[WC];
        longint mx;
        int     idx;
        for (int c = 0; c < WC; c++) begin
`ifdef ARGMAX_SIGNED_EN
            v[c] = $signed(row[c]);
`else
            v[c] = longint'(row[c]);
`endif
        end
        mx = v[0];
        for (int c = 1; c < WC; c++) if (v[c] > mx) mx = v[c];
        idx = 0;
        for (int c = WC - 1; c >= 0; c--) if (v[c] == mx) idx = c;
        return MAW'(idx);
    endfunction

    task automatic set_row(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c);
        mem[r] = {c, b, a};
    endtask

    task automatic pop_compare(input string tag);
        logic [MAW-1:0] e;
        for (int r = 0; r < FR; r++) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s scoreboard row %0d: got %0d, queue empty", tag, r, max_addi_ans[r]);
            end else begin
                e = exp_q.pop_front();
                if (max_addi_ans[r] !== e) begin
                    n_err++;
                    $display("FAIL %s result row %0d: got %0d exp %0d", tag, r, max_addi_ans[r], e);
                end
            end
        end
    endtask

    // Called at a negedge in IDLE with mem loaded; start is sampled at the end of this cycle (T).
    task automatic do_run(input string tag);
        logic [MAW-1:0] er[FR];
        logic [MAW-1:0] want;
        for (int r = 0; r < FR; r++) begin
            er[r] = ref_argmax(mem[r]);
            exp_q.push_back(er[r]);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= FR + 2; k++) begin
            if (k > 1) @(negedge clk);
            n_vec++;
            if (busy !== (k <= FR + 1)) begin
                n_err++;
                $display("FAIL %s busy T+%0d: got %b exp %b", tag, k, busy, k <= FR + 1);
            end
            n_vec++;
            if (rd_en !== (k <= FR)) begin
                n_err++;
                $display("FAIL %s rd_en T+%0d: got %b exp %b", tag, k, rd_en, k <= FR);
            end
            if (k <= FR) begin
                n_vec++;
                if (rd_addr !== RAW'(k - 1)) begin
                    n_err++;
                    $display("FAIL %s rd_addr T+%0d: got %0d exp %0d", tag, k, rd_addr, k - 1);
                end
            end
            n_vec++;
            if (done !== (k == FR + 2)) begin
                n_err++;
                $display("FAIL %s done T+%0d: got %b exp %b", tag, k, done, k == FR + 2);
            end
            for (int r = 0; r < FR; r++) begin
                want = (k >= 3 + r) ? er[r] : '0;
                n_vec++;
                if (max_addi_ans[r] !== want) begin
                    n_err++;
                    $display("FAIL %s visible row %0d T+%0d: got %0d exp %0d", tag, r, k,
                             max_addi_ans[r], want);
                end
            end
            if (done === 1'b1) pop_compare(tag);
        end
        // Results must hold while idle, despite garbage on rd_data.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ((busy | done | rd_en) !== 1'b0) begin
                n_err++;
                $display("FAIL %s idle ctl: got busy=%b done=%b rd_en=%b exp 0", tag, busy, done, rd_en);
            end
            for (int r = 0; r < FR; r++) begin
                n_vec++;
                if (max_addi_ans[r] !== er[r]) begin
                    n_err++;
                    $display("FAIL %s hold row %0d: got %0d exp %0d", tag, r, max_addi_ans[r], er[r]);
                end
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        n_vec++;
        if ({busy, done, rd_en} !== 3'b000 || rd_addr !== '0 || max_addi_ans !== '0) begin
            n_err++;
            $display("FAIL %s: got busy=%b done=%b rd_en=%b rd_addr=%0d ans=%h exp all 0",
                     tag, busy, done, rd_en, rd_addr, max_addi_ans);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        @(negedge clk);
        check_cleared("post_reset_idle");
    endtask

    task automatic test_basic();
        logic [MAW-1:0] spec_ans[FR];
        spec_ans = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
        set_row(0, 5, 9, 2);
        set_row(1, 7, 1, 3);
        set_row(2, 0, 0, 8);
        set_row(3, 4, 4, 1);
        set_row(4, 2, 6, 6);
        set_row(5, 1, 1, 1);
        do_run("basic");
        for (int r = 0; r < FR; r++) begin
            n_vec++;
            if (max_addi_ans[r] !== spec_ans[r]) begin
                n_err++;
                $display("FAIL basic_const row %0d: got %0d exp %0d", r, max_addi_ans[r], spec_ans[r]);
            end
        end
    endtask

    task automatic test_ties_sign();
        set_row(0, 3, 3, 3);
        set_row(1, 1, 9, 9);
        set_row(2, 9, 1, 9);
        set_row(3, 16'hFFFF, 16'h0001, 16'h0000);
        set_row(4, 0, 0, 0);
        set_row(5, 16'h8000, 16'h7FFF, 16'hFFFE);
        do_run("ties_sign");
        n_vec++;
`ifdef ARGMAX_SIGNED_EN
        if (max_addi_ans[3] !== 2'd1 || max_addi_ans[5] !== 2'd1) begin
`else
        if (max_addi_ans[3] !== 2'd0 || max_addi_ans[5] !== 2'd2) begin
`endif
            n_err++;
            $display("FAIL sign rows 3/5: got %0d/%0d", max_addi_ans[3], max_addi_ans[5]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            for (int r = 0; r < FR; r++)
                set_row(r, DW'($urandom_range(0, 3)) ^ (($urandom_range(0, 3) == 0) ? 16'hFFF0 : 16'h0),
                        DW'($urandom_range(0, 3)), DW'($urandom_range(0, 3)) | 16'h8000 * DW'(n & 1));
            do_run("random");
        end
    endtask

    task automatic test_back_to_back();
        int  n_done = 0;
        bit  exp_done, exp_busy;
        for (int r = 0; r < FR; r++) set_row(r, DW'(r), DW'(5 - r), 16'd2);
        for (int n = 0; n < 3; n++)
            for (int r = 0; r < FR; r++) exp_q.push_back(ref_argmax(mem[r]));
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            exp_done = (k == 8) || (k == 17) || (k == 26);
            exp_busy = (k >= 1 && k <= 7) || (k >= 10 && k <= 16) || (k >= 19 && k <= 25);
            n_vec++;
            if (done !== exp_done || busy !== exp_busy) begin
                n_err++;
                $display("FAIL b2b T+%0d: got done=%b busy=%b exp done=%b busy=%b",
                         k, done, busy, exp_done, exp_busy);
            end
            if (done === 1'b1) begin
                n_done++;
                pop_compare("b2b");
            end
            if (k == 20) start = 1'b0;
        end
        n_vec++;
        if (n_done != 3) begin
            n_err++;
            $display("FAIL b2b done count: got %0d exp 3", n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int r = 0; r < FR; r++) set_row(r, 16'd1, 16'd7, 16'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_cleared("reset_mid_run");
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_cleared("abort_quiet");
        end
        do_run("after_abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties_sign();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
